// File: rtl/series_pkg.sv
// Shared definitions for the series evaluator controller: state encoding and term-count clamp.
package series_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    LOAD   = 3'd2,
    SQUARE = 3'd3,
    ACCUM  = 3'd4,
    TERM   = 3'd5,
    DONE   = 3'd6
  } state_e;

  // Zero requested terms still evaluates one; requests above the table depth saturate.
  function automatic int unsigned clamp_terms(input int unsigned n, input int unsigned max_terms);
    int unsigned r;
    r = n;
    if (n == 0) r = 1;
    else if (n > max_terms) r = max_terms;
    return r;
  endfunction

endpackage

// File: rtl/term_counter.sv
// Term index counter: cleared at run start, advanced once per TERM, flags the final term.
module term_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W:0]   limit,
  output logic [CNT_W-1:0] idx,
  output logic             last
);

  logic [CNT_W-1:0] idx_q, idx_d;

  // Saturate at the final term so the index can never wrap past the table.
  always_comb begin
    idx_d = idx_q;
    if (clr)             idx_d = '0;
    else if (en && !last) idx_d = idx_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign last = ({1'b0, idx_q} == (limit - (CNT_W+1)'(1)));
  assign idx  = idx_q;

endmodule

// File: rtl/series_controller.sv
// Moore sequencer for the multi-function truncated power-series datapath and coefficient ROM.
module series_controller
  import series_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned CNT_W     = $clog2(MAX_TERMS),
  parameter int unsigned FUNC_W    = 1,
  parameter int unsigned ADDR_W    = FUNC_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [FUNC_W-1:0] func_sel,
  input  logic [CNT_W:0]    n_terms,
  input  logic              ovf,
  output logic              init,
  output logic              xsel,
  output logic              termxsel,
  output logic              xlden,
  output logic              termlden,
  output logic              x2sel,
  output logic              x2multsel,
  output logic              multsel,
  output logic              romsel,
  output logic              acclden,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [CNT_W-1:0]  term_idx,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state
);

  state_e             ps_q, ps_d;
  logic [FUNC_W-1:0]  func_q, func_d;
  logic [CNT_W:0]     nterm_q, nterm_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cnt_clr, cnt_en, cnt_last, ovf_hit;

  term_counter #(.CNT_W(CNT_W)) u_term_counter (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (nterm_q),
    .idx   (term_idx),
    .last  (cnt_last)
  );

  // Next state and strobe decode; strobes depend on the present state only.
  always_comb begin
    ps_d      = ps_q;
    init      = 1'b0;
    xsel      = 1'b0;
    termxsel  = 1'b0;
    xlden     = 1'b0;
    termlden  = 1'b0;
    x2sel     = 1'b0;
    x2multsel = 1'b0;
    multsel   = 1'b0;
    romsel    = 1'b0;
    acclden   = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    ovf_hit   = 1'b0;
    func_d    = func_q;
    nterm_d   = nterm_q;
    err_d     = err_q;

    case (ps_q)
      IDLE: begin
        ready = 1'b1;
        if (start) ps_d = ARMED;
      end
      ARMED: begin
        if (!start) begin
          ps_d    = LOAD;
          func_d  = func_sel;
          nterm_d = (CNT_W+1)'(clamp_terms(32'(n_terms), MAX_TERMS));
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        init     = 1'b1;
        xsel     = 1'b1;
        termxsel = 1'b1;
        xlden    = 1'b1;
        termlden = 1'b1;
        cnt_clr  = !abort;
        ps_d     = abort ? IDLE : SQUARE;
      end
      SQUARE: begin
        busy      = 1'b1;
        x2sel     = 1'b1;
        x2multsel = 1'b1;
        xlden     = 1'b1;
        ps_d      = abort ? IDLE : ACCUM;
      end
      ACCUM: begin
        busy    = 1'b1;
        romsel  = 1'b1;
        acclden = 1'b1;
        ovf_hit = ovf && !abort;
        if (abort)                ps_d = IDLE;
        else if (ovf || cnt_last) ps_d = DONE;
        else                      ps_d = TERM;
      end
      TERM: begin
        busy      = 1'b1;
        x2multsel = 1'b1;
        multsel   = 1'b1;
        termlden  = 1'b1;
        cnt_en    = !abort;
        ovf_hit   = ovf && !abort;
        if (abort)    ps_d = IDLE;
        else if (ovf) ps_d = DONE;
        else          ps_d = ACCUM;
      end
      DONE: begin
        busy = 1'b1;
        ps_d = IDLE;
      end
      default: ps_d = IDLE;
    endcase

    if (ovf_hit) err_d = 1'b1;
    done_d = (ps_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q    <= IDLE;
      func_q  <= '0;
      nterm_q <= (CNT_W+1)'(1);
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      func_q  <= func_d;
      nterm_q <= nterm_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_addr = {func_q, term_idx};
  assign done     = done_q;
  assign err      = err_q;
  assign state    = ps_q;

endmodule

// File: doc/series_controller.md
Name: series_controller

Overview:
- Parametrised Moore controller for a multi-function truncated power-series evaluator.
- Generalises the fixed tangent sequencer in three ways:
  - owns its own term counter instead of taking an external count-done input;
  - takes a per-run programmable term count;
  - selects among several coefficient tables through a function select, and adds abort, overflow-error and done-pulse behaviour.
- Sits between the top-level start/abort push-button logic and the existing x / x² / term / accumulator datapath and coefficient ROM.

Parameters:
- MAX_TERMS, 8, largest supported number of series terms (≥2).
- CNT_W, $clog2(MAX_TERMS), derived; width of term index.
- FUNC_W, 1, width of function select (2**FUNC_W coefficient tables).
- ADDR_W, FUNC_W+CNT_W, derived; ROM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; level from a debounced button.
- abort  in  1  cancel the current run.
- func_sel  in  FUNC_W  coefficient table to use.
- n_terms  in  CNT_W+1  requested number of terms.
- ovf  in  1  datapath overflow flag.
- init, xsel, termxsel, xlden, termlden  out  1 each  load strobes.
- x2sel, x2multsel, multsel, romsel, acclden  out  1 each  datapath controls.
- rom_addr  out  ADDR_W  {func_q, term_idx}.
- term_idx  out  CNT_W  current term.
- ready, busy, done, err  out  1 each  status.
- state  out  3  present-state debug.

Behaviour:
- Reset (rst=0, async):
  - ps=IDLE; term_idx=0; func_q=0; nterm_q=1; done=0; err=0.
  - Outputs decode IDLE: ready=1, every other strobe 0, busy=0.
- Strobes and ready/busy are combinational decode of ps only (Moore). done and err are registers.
- Every strobe defaults to 0 in every state. busy=1 in LOAD..DONE.
- States and transitions:
  - IDLE (ready=1): start=1 → ARMED.
  - ARMED (busy=0): waits for start release. On start=0 → LOAD; on that edge latch func_q←func_sel and nterm_q←clamp(n_terms).
  - LOAD: init, xsel, termxsel, xlden, termlden=1; term_idx←0; err←0 → SQUARE.
  - SQUARE: x2sel, x2multsel, xlden=1 → ACCUM.
  - ACCUM: romsel, acclden=1; rom_addr={func_q,term_idx}.
    - term_idx==nterm_q-1 → DONE.
    - else → TERM.
  - TERM: x2multsel, multsel, termlden=1; term_idx←term_idx+1 → ACCUM.
  - DONE: done=1 for exactly this one cycle → IDLE.
- clamp(n_terms): 0 → 1; >MAX_TERMS → MAX_TERMS; otherwise unchanged.
- Latency: leaving ARMED to done=1 is 2·nterm_q+1 cycles; back in IDLE one cycle later.
- ovf sampled high in ACCUM or TERM:
  - err←1 and next state DONE, overriding the normal transition; done still pulses.
  - err holds until the next LOAD.
- abort=1 in any of LOAD/SQUARE/ACCUM/TERM → IDLE next cycle.
  - No done pulse; err unchanged; term_idx held.
  - abort has no effect in IDLE, ARMED or DONE.
- Simultaneous abort and ovf: abort wins.
- start high in DONE is ignored. Start held from DONE into IDLE → ARMED next cycle, so a new run needs a release edge.
- term_idx never wraps: it stops at nterm_q-1 ≤ MAX_TERMS-1.
- Unreachable ps values → IDLE; all strobes 0.
- Reset asserted mid-run: immediate return to IDLE values; no done pulse.

Decomposition:
- Shared package series_pkg:
  - state encoding constants IDLE=0, ARMED=1, LOAD=2, SQUARE=3, ACCUM=4, TERM=5, DONE=6;
  - clamp function.
- One natural sub-module: term_counter.
  - Inputs: clr, en, limit.
  - Outputs: idx, last.
  - Instantiated once.

Test Plan:
- Reset, then pulse start for 3 cycles and release; n_terms=3, func_sel=1, MAX_TERMS=8:
  - acclden pulses exactly 3 times with rom_addr = 8, 9, 10;
  - done=1 exactly 7 cycles after start falls;
  - ready=1 the cycle after.
- n_terms=0: one ACCUM, zero TERM, done 3 cycles after release.
- n_terms=15: clamped to 8; 8 acclden pulses; term_idx reaches 7; done 17 cycles after release.
- ovf=1 during the second ACCUM of a 6-term run:
  - DONE next cycle with err=1;
  - err clears in the LOAD of the following run.
- abort=1 in TERM: IDLE next cycle; done never asserts; ready=1.
- rst=0 asynchronously mid-SQUARE: all strobes drop without a clock edge; state=0; start held through reset release goes to ARMED, not LOAD.
